// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: arbiter state encoding and datapath widths.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the unified-memory arbiter.
// master = arbiter view, slave = view of the fetch/data stages plus memory.
interface mem_arbiter_if
  import rv_pkg::*;
#(
  parameter int unsigned AW = XLEN,
  parameter int unsigned DW = XLEN
);
  localparam int unsigned BW = DW / 8;

  // fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  // data requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_valid;

  // status
  logic          bus_err;
  logic          stall;

  // memory port
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_ready, mem_rdata,
    output if_rdata, if_valid,
    output d_rdata, d_valid,
    output bus_err, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_ready, mem_rdata,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid,
    input  bus_err, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Wait-state counter for the memory arbiter; expired holds once TIMEOUT
// stalled grant cycles have been counted, until the next clear.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing unified memory between IF and D stages.
// Optional wait-state abort enabled with `define ARB_TIMEOUT_EN.
module mem_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned AW = XLEN,
  parameter int unsigned DW = XLEN
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned BW = DW / 8;

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic          grant_c;
  logic          done_c;
  logic          timeout_c;

  logic          if_valid_c;
  logic          d_valid_c;
  logic [DW-1:0] if_rdata_c;
  logic [DW-1:0] d_rdata_c;
  logic          bus_err_c;
  logic          stall_c;

  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [BW-1:0] mem_be_q;

`ifdef ARB_TIMEOUT_EN
  logic expired_c;
  logic ctr_clr_c;
  logic ctr_en_c;

  // counter restarts on every grant and stays clear while idle
  assign ctr_clr_c = grant_c || (state_q == IDLE);
  assign ctr_en_c  = (state_q != IDLE) && !bus.mem_ready;

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr_c),
    .en      (ctr_en_c),
    .expired (expired_c)
  );

  // a ready arriving together with expiry wins as a normal completion
  assign timeout_c = (state_q != IDLE) && expired_c && !bus.mem_ready;
`else
  assign timeout_c = 1'b0;
`endif

  assign done_c = (state_q != IDLE) && (bus.mem_ready || timeout_c);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: D beats IF; the requester just finished sits out this edge
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          state_d = GNT_D;
        end else if (bus.if_req) begin
          state_d = GNT_IF;
        end
      end
      GNT_IF: begin
        if (done_c) begin
          state_d = bus.d_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (done_c) begin
          state_d = bus.if_req ? GNT_IF : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    grant_c = (state_d != IDLE) && ((state_q == IDLE) || done_c);
  end

  // completion outputs and pipeline stall
  always_comb begin
    if_valid_c = 1'b0;
    d_valid_c  = 1'b0;
    if_rdata_c = '0;
    d_rdata_c  = '0;
    bus_err_c  = 1'b0;
    stall_c    = 1'b0;
    if (done_c) begin
      if_valid_c = (state_q == GNT_IF);
      d_valid_c  = (state_q == GNT_D);
      bus_err_c  = timeout_c;
      if (bus.mem_ready) begin
        if_rdata_c = (state_q == GNT_IF) ? bus.mem_rdata : '0;
        d_rdata_c  = (state_q == GNT_D)  ? bus.mem_rdata : '0;
      end
    end
    stall_c = (bus.if_req && !if_valid_c) || (bus.d_req && !d_valid_c);
  end

  // memory attributes latched at grant, held until completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      mem_req_q <= (state_d != IDLE);
      if (grant_c) begin
        if (state_d == GNT_D) begin
          mem_we_q    <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
          mem_be_q    <= bus.d_be;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
        end
      end
    end
  end

  assign bus.if_valid  = if_valid_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.d_valid   = d_valid_c;
  assign bus.d_rdata   = d_rdata_c;
  assign bus.bus_err   = bus_err_c;
  assign bus.stall     = stall_c;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs driven 1 time unit after rising
// edges, outputs sampled on falling edges.
module tb_mem_arbiter;
  import rv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_TIMEOUT_EN
  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if ({bus.mem_we, bus.mem_be, bus.mem_wdata} !== 37'h0) begin errors++; $display("FAIL rst_mem_attr: got %h want 0", {bus.mem_we, bus.mem_be, bus.mem_wdata}); end
    checks++; if ({bus.if_valid, bus.d_valid, bus.bus_err, bus.stall} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {bus.if_valid, bus.d_valid, bus.bus_err, bus.stall}); end
    bus.if_req    = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    checks++; if ({bus.stall, bus.if_valid} !== 2'b10) begin errors++; $display("FAIL rst_stall_follows: got %b want 10", {bus.stall, bus.if_valid}); end
    drive_pt();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_held_mem_req: got %b want 0", bus.mem_req); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    drive_pt();
  endtask

  task automatic test_single_fetch();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++; if ({bus.mem_req, bus.if_valid, bus.stall} !== 3'b001) begin errors++; $display("FAIL sf_c0: got req/valid/stall %b want 001", {bus.mem_req, bus.if_valid, bus.stall}); end
    drive_pt();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sf_c1_grant: got req %b addr %h want 1 100", bus.mem_req, bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL sf_c1_we_be: got %b %h want 0 0", bus.mem_we, bus.mem_be); end
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.stall !== 1'b0) begin errors++; $display("FAIL sf_c1_done: got valid %b rdata %h stall %b want 1 00500093 0", bus.if_valid, bus.if_rdata, bus.stall); end
    drive_pt();
    bus.if_req = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sf_c2_idle: got %b want 0", bus.mem_req); end
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'h0) begin errors++; $display("FAIL sf_ready_in_idle: got valid %b rdata %h want 0 0", bus.if_valid, bus.if_rdata); end
    drive_pt();
    clear_inputs();
  endtask

  task automatic test_contention();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ct_c0: got stall %b req %b want 1 0", bus.stall, bus.mem_req); end
    for (int c = 1; c <= 2; c++) begin
      drive_pt();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ct_wait%0d_attr: got req %b addr %h we %b want 1 200 0", c, bus.mem_req, bus.mem_addr, bus.mem_we); end
      @(negedge clk);
      checks++; if (bus.d_valid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.stall !== 1'b1) begin errors++; $display("FAIL ct_wait%0d_out: got valid %b rdata %h stall %b want 0 0 1", c, bus.d_valid, bus.d_rdata, bus.stall); end
    end
    drive_pt();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1122_3344 || bus.if_valid !== 1'b0 || bus.stall !== 1'b1) begin errors++; $display("FAIL ct_c3_d_done: got dv %b rdata %h iv %b stall %b want 1 11223344 0 1", bus.d_valid, bus.d_rdata, bus.if_valid, bus.stall); end
    drive_pt();
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'hAAAA_5555;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ct_c4_if_grant: got req %b addr %h we %b want 1 100 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hAAAA_5555 || bus.d_valid !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL ct_c4_if_done: got iv %b rdata %h dv %b stall %b want 1 aaaa5555 0 0", bus.if_valid, bus.if_rdata, bus.d_valid, bus.stall); end
    drive_pt();
    clear_inputs();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL ct_c5_idle: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_store();
    int nvalid;
    nvalid = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'b0011;
    @(negedge clk);
    if (bus.d_valid === 1'b1) nvalid++;
    for (int c = 1; c <= 4; c++) begin
      drive_pt();
      if (c == 1) begin
        bus.d_addr  = 32'h44;
        bus.d_wdata = 32'h0BAD_F00D;
      end
      if (c == 4) bus.mem_ready = 1'b1;
      checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL st_attr_c%0d: got req %b we %b addr %h wdata %h be %b want 1 1 40 deadbeef 0011", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
      @(negedge clk);
      if (bus.d_valid === 1'b1) nvalid++;
    end
    checks++; if (bus.d_valid !== 1'b1 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL st_done: got valid %b err %b want 1 0", bus.d_valid, bus.bus_err); end
    drive_pt();
    clear_inputs();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL st_idle: got %b want 0", bus.mem_req); end
    @(negedge clk);
    if (bus.d_valid === 1'b1) nvalid++;
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL st_valid_pulses: got %0d want 1", nvalid); end
    drive_pt();
  endtask

  task automatic test_regrant();
    int n100;
    int n104;
    n100 = 0;
    n104 = 0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0001;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) drive_pt();
      if (c == 2) begin
        bus.if_addr   = 32'h104;
        bus.mem_rdata = 32'h0000_0002;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rg_no_regrant: got %b want 0", bus.mem_req); end
      end
      if (c == 3) begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104) begin errors++; $display("FAIL rg_new_grant: got req %b addr %h want 1 104", bus.mem_req, bus.mem_addr); end
      end
      if (c == 4) bus.if_req = 1'b0;
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
        if (bus.mem_addr === 32'h100) n100++;
        if (bus.mem_addr === 32'h104) n104++;
      end
      if (c == 3) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h2) begin errors++; $display("FAIL rg_second_data: got valid %b rdata %h want 1 2", bus.if_valid, bus.if_rdata); end
      end
    end
    checks++; if (n100 !== 1 || n104 !== 1) begin errors++; $display("FAIL rg_txn_count: got 100:%0d 104:%0d want 1 1", n100, n104); end
    drive_pt();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h300;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    drive_pt();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h400;
    checks++; if (bus.mem_addr !== 32'h300) begin errors++; $display("FAIL bb_if_addr: got %h want 300", bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.d_valid !== 1'b0 || bus.stall !== 1'b1) begin errors++; $display("FAIL bb_if_done: got iv %b dv %b stall %b want 1 0 1", bus.if_valid, bus.d_valid, bus.stall); end
    drive_pt();
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'hCAFE_0002;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL bb_no_bubble: got req %b addr %h we %b want 1 400 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL bb_d_done: got valid %b rdata %h want 1 cafe0002", bus.d_valid, bus.d_rdata); end
    drive_pt();
    clear_inputs();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bb_idle: got %b want 0", bus.mem_req); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h80;
    bus.mem_rdata = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      drive_pt();
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.d_valid, bus.bus_err} !== 3'b100) begin errors++; $display("FAIL to_wait%0d: got req/valid/err %b want 100", c, {bus.mem_req, bus.d_valid, bus.bus_err}); end
    end
    drive_pt();
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.bus_err !== 1'b1 || bus.d_rdata !== 32'h0 || bus.stall !== 1'b0) begin errors++; $display("FAIL to_abort: got valid %b err %b rdata %h stall %b want 1 1 0 0", bus.d_valid, bus.bus_err, bus.d_rdata, bus.stall); end
    drive_pt();
    bus.d_req = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", bus.mem_req); end
    drive_pt();
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h84;
    bus.mem_ready = 1'b1;
    drive_pt();
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.bus_err !== 1'b0 || bus.d_rdata !== 32'h1234_5678 || bus.mem_addr !== 32'h84) begin errors++; $display("FAIL to_recover: got valid %b err %b rdata %h addr %h want 1 0 12345678 84", bus.d_valid, bus.bus_err, bus.d_rdata, bus.mem_addr); end
    drive_pt();
    clear_inputs();
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic [BE_W-1:0] be_full;
    be_full     = '1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h60;
    bus.d_wdata = 32'h55;
    bus.d_be    = be_full;
    drive_pt();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_be !== be_full) begin errors++; $display("FAIL rm_granted: got req %b be %b want 1 1111", bus.mem_req, bus.mem_be); end
    drive_pt();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got req %b addr %h we %b want 0 0 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.d_valid !== 1'b0 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL rm_no_valid_in_rst: got valid %b err %b want 0 0", bus.d_valid, bus.bus_err); end
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_pt();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_post_idle: got %b want 0", bus.mem_req); end
    @(negedge clk);
    checks++; if ({bus.d_valid, bus.if_valid, bus.bus_err, bus.stall} !== 4'b0000) begin errors++; $display("FAIL rm_no_stale: got %b want 0000", {bus.d_valid, bus.if_valid, bus.bus_err, bus.stall}); end
    drive_pt();
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_regrant();
    test_back_to_back();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
